// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream and command-port bundle for the UART frame decoder.
// slave is the decoder side; master is the producer/consumer side.
interface uart_cmd_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        err_checksum;
  logic        err_timeout;

  modport slave (
    input  rx_data, rx_data_valid, cmd_ready,
    output rx_data_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_checksum, err_timeout
  );

  modport master (
    output rx_data, rx_data_valid, cmd_ready,
    input  rx_data_ready, cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_checksum, err_timeout
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frame decoder behind the UART receiver: SYNC, OP, ADDR, [D0..D3], CHK -> register command.
// Bad checksums and inter-byte gaps drop the frame with a one-cycle error pulse.
module uart_cmd_ctrl #(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input logic            clk,
  input logic            rst_n,
  uart_cmd_ctrl_if.slave bus
);

  localparam int unsigned TimeoutCyc = CLK_FRE * TIMEOUT_US;
  localparam logic [31:0] GapLast    = 32'(TimeoutCyc - 1);

  typedef enum logic [2:0] {StSync, StOp, StAddr, StData, StChk, StIssue} state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  xor_q, xor_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] gap_q, gap_d, gap_inc;
  logic        cmd_write_q, cmd_write_d;
  logic [7:0]  cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic        err_chk_q, err_chk_d;
  logic        err_to_q, err_to_d;
  logic        accept;
  logic        in_frame;

  assign bus.rx_data_ready = (state_q != StIssue);
  assign accept            = bus.rx_data_valid && bus.rx_data_ready;
  assign in_frame          = state_q inside {StOp, StAddr, StData, StChk};
  assign gap_inc           = gap_q + 32'd1;

  assign bus.cmd_valid    = (state_q == StIssue);
  assign bus.cmd_write    = cmd_write_q;
  assign bus.cmd_addr     = cmd_addr_q;
  assign bus.cmd_wdata    = cmd_wdata_q;
  assign bus.err_checksum = err_chk_q;
  assign bus.err_timeout  = err_to_q;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    xor_d       = xor_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    gap_d       = '0;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    err_chk_d   = 1'b0;
    err_to_d    = 1'b0;

    unique case (state_q)
      StSync: begin
        if (accept && bus.rx_data == SYNC_BYTE) begin
          xor_d   = '0;
          state_d = StOp;
        end
      end
      StOp: begin
        // A SYNC_BYTE value here is an opcode, not a resync.
        if (accept) begin
          wr_d    = bus.rx_data[0];
          xor_d   = bus.rx_data;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (accept) begin
          addr_d  = bus.rx_data;
          xor_d   = xor_q ^ bus.rx_data;
          wdata_d = '0;
          idx_d   = '0;
          state_d = wr_q ? StData : StChk;
        end
      end
      StData: begin
        if (accept) begin
          wdata_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
          xor_d = xor_q ^ bus.rx_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = StChk;
        end
      end
      StChk: begin
        if (accept) begin
          if (bus.rx_data == xor_q) begin
            cmd_write_d = wr_q;
            cmd_addr_d  = addr_q;
            cmd_wdata_d = wdata_q;
            state_d     = StIssue;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StSync;
          end
        end
      end
      StIssue: begin
        if (bus.cmd_ready) state_d = StSync;
      end
      default: state_d = StSync;
    endcase

    // An accept in the terminal-count cycle suppresses the timeout.
    if (in_frame && !accept) begin
      if (gap_inc == GapLast) begin
        err_to_d = 1'b1;
        state_d  = StSync;
      end else begin
        gap_d = gap_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSync;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      xor_q       <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      err_chk_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      xor_q       <= xor_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      err_chk_q   <= err_chk_d;
      err_to_q    <= err_to_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomized bench for uart_cmd_ctrl: frames are generated at transaction level and the
// expected commands / error pulses are tracked in a scoreboard.
module tb_uart_cmd_ctrl;
  localparam int unsigned ClkFre     = 50;
  localparam int unsigned TimeoutUs  = 1;
  localparam int unsigned TimeoutCyc = ClkFre * TimeoutUs;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(
    .CLK_FRE   (ClkFre),
    .TIMEOUT_US(TimeoutUs),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_err_chk = 0;
  int   n_err_to = 0;
  int   exp_chk = 0;
  int   exp_to = 0;
  int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  int   max_gap = 2;
  cmd_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, bus.rx_data_ready, 1);
    check({tag, "_valid"}, bus.cmd_valid, 0);
    check({tag, "_write"}, bus.cmd_write, 0);
    check({tag, "_addr"}, bus.cmd_addr, 0);
    check({tag, "_wdata"}, bus.cmd_wdata, 0);
    check({tag, "_errs"}, {bus.err_checksum, bus.err_timeout}, 0);
  endtask

  // Present one byte and hold it until accepted; returns at accept edge + 1.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rx_data_ready && n < 1000);
    if (!bus.rx_data_ready) check("accept_wait", 0, 1);
    @(posedge clk);
    #1;
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [31:0] data, input logic bad, input int n_garb);
    logic [7:0] chk, b;
    cmd_t       c;
    for (int i = 0; i < n_garb; i++) begin
      do b = 8'($urandom); while (b == 8'hA5);
      send_byte(b);
    end
    chk = op ^ addr;
    send_byte(8'hA5);
    idle($urandom_range(0, max_gap));
    send_byte(op);
    idle($urandom_range(0, max_gap));
    send_byte(addr);
    if (op[0]) begin
      for (int i = 0; i < 4; i++) begin
        b = data[8*i +: 8];
        chk ^= b;
        idle($urandom_range(0, max_gap));
        send_byte(b);
      end
    end
    if (bad) begin
      chk ^= 8'(1 << $urandom_range(0, 7));
      exp_chk++;
    end else begin
      c.wr    = op[0];
      c.addr  = addr;
      c.wdata = op[0] ? data : 32'h0;
      exp_q.push_back(c);
    end
    idle($urandom_range(0, max_gap));
    send_byte(chk);
  endtask

  initial begin
    bus.cmd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.cmd_ready = 1'b0;
        1:       bus.cmd_ready = 1'b1;
        default: bus.cmd_ready = 1'($urandom);
      endcase
    end
  end

  // Monitor: handshakes against the scoreboard, stability while stalled, error pulse counts.
  initial begin
    logic held;
    cmd_t prev, e;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (bus.err_checksum) n_err_chk++;
        if (bus.err_timeout) n_err_to++;
        check("err_overlap", bus.err_checksum & bus.err_timeout, 0);
        check("rdy_vs_valid", bus.rx_data_ready, !bus.cmd_valid);
        if (bus.cmd_valid && held) check("stall_stable", {bus.cmd_write, bus.cmd_addr,
                                                          bus.cmd_wdata}, prev);
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (exp_q.size() == 0) begin
            check("cmd_unexpected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("cmd_write", bus.cmd_write, e.wr);
            check("cmd_addr", bus.cmd_addr, e.addr);
            check("cmd_wdata", bus.cmd_wdata, e.wdata);
          end
        end
        held = bus.cmd_valid && !bus.cmd_ready;
        prev = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
      end
    end
  end

  initial begin
    int   seen;
    logic wr;
    bus.rx_data       = '0;
    bus.rx_data_valid = 1'b0;
    rst_n             = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Directed frames from the datasheet examples
    send_frame(8'h01, 8'h10, 32'h11223344, 1'b0, 0);
    send_frame(8'h00, 8'h3C, 32'h0, 1'b0, 0);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    send_frame(8'h00, 8'h3C, 32'h0, 1'b0, 0);
    send_frame(8'h00, 8'h3C, 32'h0, 1'b1, 0);
    send_frame(8'h01, 8'hA5, 32'hA5A5_00FF, 1'b0, 0);
    idle(3);
    check("chk_count", n_err_chk, exp_chk);

    // Inter-byte timeout: pulse lands TimeoutCyc-1 edges after the last accept
    send_byte(8'hA5);
    send_byte(8'h01);
    seen = 0;
    for (int k = 1; k <= int'(TimeoutCyc) + 10 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.err_timeout) seen = k;
    end
    exp_to++;
    check("to_cycle", seen, TimeoutCyc - 1);
    idle(1);
    check("to_pulse", bus.err_timeout, 0);
    send_frame(8'h00, 8'h77, 32'h0, 1'b0, 0);
    idle(3);

    // A byte accepted in the terminal-count cycle wins
    begin
      cmd_t c;
      send_byte(8'hA5);
      send_byte(8'h01);
      idle(TimeoutCyc - 2);
      c.wr = 1'b1; c.addr = 8'h20; c.wdata = 32'h0403_0201;
      exp_q.push_back(c);
      send_byte(8'h20);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h04);
      send_byte(8'h01 ^ 8'h20 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
    end
    idle(3);
    check("to_term", n_err_to, exp_to);

    // Consumer stall: command held, input blocked
    ready_mode = 0;
    send_frame(8'h81, 8'h5A, 32'hDEAD_BEEF, 1'b0, 0);
    bus.rx_data       = 8'hA5;
    bus.rx_data_valid = 1'b1;
    idle(20);
    check("stall_valid", bus.cmd_valid, 1);
    check("stall_rdy", bus.rx_data_ready, 0);
    ready_mode = 1;
    send_frame(8'h00, 8'h5B, 32'h0, 1'b0, 0);
    idle(3);

    // Randomized traffic
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      wr = 1'($urandom);
      send_frame({7'($urandom), wr}, 8'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 2));
      idle($urandom_range(0, 3));
    end
    ready_mode = 1;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || bus.cmd_valid); k++) idle(1);
    idle(2);

    // Reset in the middle of the data bytes
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'h44);
    rst_n = 1'b0;
    idle(2);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    idle(3);
    check("midrst_novalid", bus.cmd_valid, 0);
    send_frame(8'h00, 8'h42, 32'h0, 1'b0, 0);
    for (int k = 0; k < 50 && (exp_q.size() != 0 || bus.cmd_valid); k++) idle(1);
    idle(2);

    check("q_empty", exp_q.size(), 0);
    check("chk_total", n_err_chk, exp_chk);
    check("to_total", n_err_to, exp_to);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
